// File: rtl/rename_pkg.sv
// Shared defaults and small helpers for the N-wide rename stage.
package rename_pkg;

    localparam int RN_WIDTH_DEF = 2;
    localparam int LREG_W_DEF   = 5;
    localparam int PREG_W_DEF   = 6;
    localparam int CNT_W_DEF    = 32;
    localparam int MAX_WIDTH    = 4;

    function automatic int popcount(input logic [MAX_WIDTH-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    // Width of a slot index; a 1-wide group still needs one bit to carry it.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rename_depcheck.sv
// Intra-group dependency check: RAW bypass sources for rs1/rs2/old-rd per slot and WAW suppress mask.
module rename_depcheck
    import rename_pkg::*;
#(
    parameter int RN_WIDTH = RN_WIDTH_DEF,
    parameter int LREG_W   = LREG_W_DEF,
    parameter int IDX_W    = idx_w(RN_WIDTH_DEF)
) (
    input  logic [RN_WIDTH-1:0]        dst,
    input  logic [RN_WIDTH*LREG_W-1:0] lrs1,
    input  logic [RN_WIDTH*LREG_W-1:0] lrs2,
    input  logic [RN_WIDTH*LREG_W-1:0] lrd,
    output logic [RN_WIDTH-1:0]        rs1_hit,
    output logic [RN_WIDTH-1:0]        rs2_hit,
    output logic [RN_WIDTH-1:0]        rd_hit,
    output logic [RN_WIDTH*IDX_W-1:0]  rs1_idx,
    output logic [RN_WIDTH*IDX_W-1:0]  rs2_idx,
    output logic [RN_WIDTH*IDX_W-1:0]  rd_idx,
    output logic [RN_WIDTH-1:0]        waw_keep
);

    // Older slots are scanned in ascending order so the youngest matching writer overwrites earlier hits.
    always_comb begin
        rs1_hit  = '0;
        rs2_hit  = '0;
        rd_hit   = '0;
        rs1_idx  = '0;
        rs2_idx  = '0;
        rd_idx   = '0;
        waw_keep = dst;
        for (int j = 0; j < RN_WIDTH; j++) begin
            for (int i = 0; i < j; i++) begin
                if (dst[i]) begin
                    if (lrd[i*LREG_W +: LREG_W] == lrs1[j*LREG_W +: LREG_W]) begin
                        rs1_hit[j]                = 1'b1;
                        rs1_idx[j*IDX_W +: IDX_W] = IDX_W'(i);
                    end
                    if (lrd[i*LREG_W +: LREG_W] == lrs2[j*LREG_W +: LREG_W]) begin
                        rs2_hit[j]                = 1'b1;
                        rs2_idx[j*IDX_W +: IDX_W] = IDX_W'(i);
                    end
                    if (lrd[i*LREG_W +: LREG_W] == lrd[j*LREG_W +: LREG_W]) begin
                        rd_hit[j]                = 1'b1;
                        rd_idx[j*IDX_W +: IDX_W] = IDX_W'(i);
                        if (dst[j]) begin
                            waw_keep[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rename_nway.sv
// N-wide rename stage: freelist compaction, RAT/bypass operand muxing, handshake and output register.
module rename_nway
    import rename_pkg::*;
#(
    parameter int RN_WIDTH = RN_WIDTH_DEF,
    parameter int LREG_W   = LREG_W_DEF,
    parameter int PREG_W   = PREG_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             dec2rn_valid,
    output logic                             rn2dec_ready,
    input  logic [RN_WIDTH-1:0]              dec2rn_slot_valid,
    input  logic [RN_WIDTH*LREG_W-1:0]       dec2rn_lrs1,
    input  logic [RN_WIDTH*LREG_W-1:0]       dec2rn_lrs2,
    input  logic [RN_WIDTH*LREG_W-1:0]       dec2rn_lrd,
    input  logic [RN_WIDTH-1:0]              dec2rn_lrs1_v,
    input  logic [RN_WIDTH-1:0]              dec2rn_lrs2_v,
    input  logic [RN_WIDTH-1:0]              dec2rn_lrd_v,
    output logic [RN_WIDTH*LREG_W-1:0]       rn2specrat_rs1,
    output logic [RN_WIDTH*LREG_W-1:0]       rn2specrat_rs2,
    output logic [RN_WIDTH*LREG_W-1:0]       rn2specrat_rd,
    input  logic [RN_WIDTH*PREG_W-1:0]       specrat2rn_prs1,
    input  logic [RN_WIDTH*PREG_W-1:0]       specrat2rn_prs2,
    input  logic [RN_WIDTH*PREG_W-1:0]       specrat2rn_prd,
    input  logic [RN_WIDTH*PREG_W-1:0]       fl2rn_prd,
    input  logic [$clog2(RN_WIDTH+1)-1:0]    fl2rn_avail,
    output logic [$clog2(RN_WIDTH+1)-1:0]    rn2fl_alloc_cnt,
    output logic [RN_WIDTH-1:0]              rn2specrat_wren,
    output logic [RN_WIDTH*LREG_W-1:0]       rn2specrat_waddr,
    output logic [RN_WIDTH*PREG_W-1:0]       rn2specrat_wdata,
    output logic                             rn2disp_valid,
    input  logic                             disp2rn_ready,
    output logic [RN_WIDTH-1:0]              rn2disp_slot_valid,
    output logic [RN_WIDTH*PREG_W-1:0]       rn2disp_prs1,
    output logic [RN_WIDTH*PREG_W-1:0]       rn2disp_prs2,
    output logic [RN_WIDTH*PREG_W-1:0]       rn2disp_prd,
    output logic [RN_WIDTH*PREG_W-1:0]       rn2disp_old_prd,
    output logic [RN_WIDTH-1:0]              rn2disp_prd_v,
    output logic [CNT_W-1:0]                 rn_stall_cnt
);

    localparam int CW = $clog2(RN_WIDTH + 1);
    localparam int IW = idx_w(RN_WIDTH);

    logic [RN_WIDTH-1:0]        dst_p0;
    logic [CW-1:0]              need_p0;
    logic                       fire_p0;
    logic [RN_WIDTH*PREG_W-1:0] new_prd_p0;
    logic [RN_WIDTH*PREG_W-1:0] prs1_p0;
    logic [RN_WIDTH*PREG_W-1:0] prs2_p0;
    logic [RN_WIDTH*PREG_W-1:0] prd_p0;
    logic [RN_WIDTH*PREG_W-1:0] old_prd_p0;
    logic [RN_WIDTH-1:0]        rs1_hit;
    logic [RN_WIDTH-1:0]        rs2_hit;
    logic [RN_WIDTH-1:0]        rd_hit;
    logic [RN_WIDTH*IW-1:0]     rs1_idx;
    logic [RN_WIDTH*IW-1:0]     rs2_idx;
    logic [RN_WIDTH*IW-1:0]     rd_idx;
    logic [RN_WIDTH-1:0]        waw_keep;

    assign rn2specrat_rs1 = dec2rn_lrs1;
    assign rn2specrat_rs2 = dec2rn_lrs2;
    assign rn2specrat_rd  = dec2rn_lrd;

    // Destinations take freelist entries in slot order, skipping slots that allocate nothing.
    always_comb begin
        int acc;
        acc        = 0;
        new_prd_p0 = '0;
        for (int k = 0; k < RN_WIDTH; k++) begin
            dst_p0[k] = dec2rn_slot_valid[k] & dec2rn_lrd_v[k] & (dec2rn_lrd[k*LREG_W +: LREG_W] != '0);
            if (dst_p0[k]) begin
                new_prd_p0[k*PREG_W +: PREG_W] = fl2rn_prd[acc*PREG_W +: PREG_W];
                acc++;
            end
        end
    end

    assign need_p0      = CW'(popcount(MAX_WIDTH'(dst_p0)));
    assign rn2dec_ready = !flush && (!rn2disp_valid || disp2rn_ready) && (need_p0 <= fl2rn_avail);
    assign fire_p0      = dec2rn_valid && rn2dec_ready;

    rename_depcheck #(
        .RN_WIDTH (RN_WIDTH),
        .LREG_W   (LREG_W),
        .IDX_W    (IW)
    ) u_depcheck (
        .dst      (dst_p0),
        .lrs1     (dec2rn_lrs1),
        .lrs2     (dec2rn_lrs2),
        .lrd      (dec2rn_lrd),
        .rs1_hit  (rs1_hit),
        .rs2_hit  (rs2_hit),
        .rd_hit   (rd_hit),
        .rs1_idx  (rs1_idx),
        .rs2_idx  (rs2_idx),
        .rd_idx   (rd_idx),
        .waw_keep (waw_keep)
    );

    always_comb begin
        prs1_p0    = '0;
        prs2_p0    = '0;
        prd_p0     = '0;
        old_prd_p0 = '0;
        for (int k = 0; k < RN_WIDTH; k++) begin
            if (dec2rn_slot_valid[k] && dec2rn_lrs1_v[k] && dec2rn_lrs1[k*LREG_W +: LREG_W] != '0) begin
                prs1_p0[k*PREG_W +: PREG_W] = rs1_hit[k]
                    ? new_prd_p0[int'(rs1_idx[k*IW +: IW])*PREG_W +: PREG_W]
                    : specrat2rn_prs1[k*PREG_W +: PREG_W];
            end
            if (dec2rn_slot_valid[k] && dec2rn_lrs2_v[k] && dec2rn_lrs2[k*LREG_W +: LREG_W] != '0) begin
                prs2_p0[k*PREG_W +: PREG_W] = rs2_hit[k]
                    ? new_prd_p0[int'(rs2_idx[k*IW +: IW])*PREG_W +: PREG_W]
                    : specrat2rn_prs2[k*PREG_W +: PREG_W];
            end
            if (dst_p0[k]) begin
                prd_p0[k*PREG_W +: PREG_W]     = new_prd_p0[k*PREG_W +: PREG_W];
                old_prd_p0[k*PREG_W +: PREG_W] = rd_hit[k]
                    ? new_prd_p0[int'(rd_idx[k*IW +: IW])*PREG_W +: PREG_W]
                    : specrat2rn_prd[k*PREG_W +: PREG_W];
            end
        end
    end

    assign rn2fl_alloc_cnt  = fire_p0 ? need_p0 : '0;
    assign rn2specrat_wren  = fire_p0 ? (dst_p0 & waw_keep) : '0;
    assign rn2specrat_waddr = dec2rn_lrd;
    assign rn2specrat_wdata = new_prd_p0;

    // ---- stage p0 -> p1: output register toward dispatch ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rn2disp_valid      <= 1'b0;
            rn2disp_slot_valid <= '0;
            rn2disp_prs1       <= '0;
            rn2disp_prs2       <= '0;
            rn2disp_prd        <= '0;
            rn2disp_old_prd    <= '0;
            rn2disp_prd_v      <= '0;
        end else if (fire_p0) begin
            rn2disp_valid      <= 1'b1;
            rn2disp_slot_valid <= dec2rn_slot_valid;
            rn2disp_prs1       <= prs1_p0;
            rn2disp_prs2       <= prs2_p0;
            rn2disp_prd        <= prd_p0;
            rn2disp_old_prd    <= old_prd_p0;
            rn2disp_prd_v      <= dst_p0;
        end else if (flush || disp2rn_ready) begin
            rn2disp_valid      <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rn_stall_cnt <= '0;
        end else if (dec2rn_valid && !rn2dec_ready && rn_stall_cnt != '1) begin
            rn_stall_cnt <= rn_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rename_nway.sv
// Directed bench for rename_nway (2-wide) with a slot-walk reference model and per-cycle comparison.
module tb_rename_nway;

    localparam int W  = 2;
    localparam int LW = 5;
    localparam int PW = 6;
    localparam int NW = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            dec2rn_valid;
    logic            rn2dec_ready;
    logic [W-1:0]    dec2rn_slot_valid;
    logic [W*LW-1:0] dec2rn_lrs1, dec2rn_lrs2, dec2rn_lrd;
    logic [W-1:0]    dec2rn_lrs1_v, dec2rn_lrs2_v, dec2rn_lrd_v;
    logic [W*LW-1:0] rn2specrat_rs1, rn2specrat_rs2, rn2specrat_rd;
    logic [W*PW-1:0] specrat2rn_prs1, specrat2rn_prs2, specrat2rn_prd;
    logic [W*PW-1:0] fl2rn_prd;
    logic [1:0]      fl2rn_avail;
    logic [1:0]      rn2fl_alloc_cnt;
    logic [W-1:0]    rn2specrat_wren;
    logic [W*LW-1:0] rn2specrat_waddr;
    logic [W*PW-1:0] rn2specrat_wdata;
    logic            rn2disp_valid;
    logic            disp2rn_ready;
    logic [W-1:0]    rn2disp_slot_valid;
    logic [W*PW-1:0] rn2disp_prs1, rn2disp_prs2, rn2disp_prd, rn2disp_old_prd;
    logic [W-1:0]    rn2disp_prd_v;
    logic [NW-1:0]   rn_stall_cnt;

    logic [LW-1:0] s_lrs1[W], s_lrs2[W], s_lrd[W];
    logic [PW-1:0] r_prs1[W], r_prs2[W], r_prd[W], fl[W];

    assign dec2rn_lrs1     = {s_lrs1[1], s_lrs1[0]};
    assign dec2rn_lrs2     = {s_lrs2[1], s_lrs2[0]};
    assign dec2rn_lrd      = {s_lrd[1], s_lrd[0]};
    assign specrat2rn_prs1 = {r_prs1[1], r_prs1[0]};
    assign specrat2rn_prs2 = {r_prs2[1], r_prs2[0]};
    assign specrat2rn_prd  = {r_prd[1], r_prd[0]};
    assign fl2rn_prd       = {fl[1], fl[0]};

    rename_nway #(.RN_WIDTH(W), .LREG_W(LW), .PREG_W(PW), .CNT_W(NW)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .dec2rn_valid(dec2rn_valid), .rn2dec_ready(rn2dec_ready),
        .dec2rn_slot_valid(dec2rn_slot_valid),
        .dec2rn_lrs1(dec2rn_lrs1), .dec2rn_lrs2(dec2rn_lrs2), .dec2rn_lrd(dec2rn_lrd),
        .dec2rn_lrs1_v(dec2rn_lrs1_v), .dec2rn_lrs2_v(dec2rn_lrs2_v), .dec2rn_lrd_v(dec2rn_lrd_v),
        .rn2specrat_rs1(rn2specrat_rs1), .rn2specrat_rs2(rn2specrat_rs2), .rn2specrat_rd(rn2specrat_rd),
        .specrat2rn_prs1(specrat2rn_prs1), .specrat2rn_prs2(specrat2rn_prs2), .specrat2rn_prd(specrat2rn_prd),
        .fl2rn_prd(fl2rn_prd), .fl2rn_avail(fl2rn_avail), .rn2fl_alloc_cnt(rn2fl_alloc_cnt),
        .rn2specrat_wren(rn2specrat_wren), .rn2specrat_waddr(rn2specrat_waddr),
        .rn2specrat_wdata(rn2specrat_wdata),
        .rn2disp_valid(rn2disp_valid), .disp2rn_ready(disp2rn_ready),
        .rn2disp_slot_valid(rn2disp_slot_valid),
        .rn2disp_prs1(rn2disp_prs1), .rn2disp_prs2(rn2disp_prs2),
        .rn2disp_prd(rn2disp_prd), .rn2disp_old_prd(rn2disp_old_prd),
        .rn2disp_prd_v(rn2disp_prd_v), .rn_stall_cnt(rn_stall_cnt)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: combinational results for the current inputs, plus expected output register.
    bit m_ready, m_fire;
    int m_need;
    bit m_wren[W], m_prdv[W];
    int m_prs1[W], m_prs2[W], m_prd[W], m_old[W], m_new[W];
    bit exp_valid = 1'b0;
    bit e_sv[W], e_prdv[W];
    int e_prs1[W], e_prs2[W], e_prd[W], e_old[W];
    int exp_stall = 0;

    // Walk slots oldest to youngest with a map of in-group renames; RAT data is the fallback.
    task automatic model_eval();
        int map[32];
        int lastw[32];
        bit d[W];
        int cnt;
        foreach (map[i]) begin
            map[i]   = -1;
            lastw[i] = -1;
        end
        m_need = 0;
        for (int k = 0; k < W; k++) begin
            d[k] = dec2rn_slot_valid[k] && dec2rn_lrd_v[k] && (s_lrd[k] != 0);
            if (d[k]) m_need++;
        end
        m_ready = !flush && (!exp_valid || disp2rn_ready) && (m_need <= int'(fl2rn_avail));
        m_fire  = dec2rn_valid && m_ready;
        cnt = 0;
        for (int k = 0; k < W; k++) begin
            m_prs1[k] = 0;
            m_prs2[k] = 0;
            if (dec2rn_slot_valid[k] && dec2rn_lrs1_v[k] && s_lrs1[k] != 0)
                m_prs1[k] = (map[s_lrs1[k]] >= 0) ? map[s_lrs1[k]] : int'(r_prs1[k]);
            if (dec2rn_slot_valid[k] && dec2rn_lrs2_v[k] && s_lrs2[k] != 0)
                m_prs2[k] = (map[s_lrs2[k]] >= 0) ? map[s_lrs2[k]] : int'(r_prs2[k]);
            m_prdv[k] = d[k];
            if (d[k]) begin
                m_old[k] = (map[s_lrd[k]] >= 0) ? map[s_lrd[k]] : int'(r_prd[k]);
                m_new[k] = int'(fl[cnt]);
                cnt++;
                map[s_lrd[k]]   = m_new[k];
                lastw[s_lrd[k]] = k;
                m_prd[k] = m_new[k];
            end else begin
                m_old[k] = 0;
                m_new[k] = 0;
                m_prd[k] = 0;
            end
        end
        for (int k = 0; k < W; k++)
            m_wren[k] = m_fire && d[k] && (lastw[s_lrd[k]] == k);
    endtask

    always @(posedge clock) begin
        if (!reset_n) begin
            exp_valid = 1'b0;
            exp_stall = 0;
            for (int k = 0; k < W; k++) begin
                e_sv[k] = 0; e_prdv[k] = 0;
                e_prs1[k] = 0; e_prs2[k] = 0; e_prd[k] = 0; e_old[k] = 0;
            end
        end else begin
            model_eval();
            if (dec2rn_valid && !m_ready && exp_stall != -1) exp_stall++;
            if (m_fire) begin
                exp_valid = 1'b1;
                for (int k = 0; k < W; k++) begin
                    e_sv[k] = dec2rn_slot_valid[k]; e_prdv[k] = m_prdv[k];
                    e_prs1[k] = m_prs1[k]; e_prs2[k] = m_prs2[k];
                    e_prd[k] = m_prd[k]; e_old[k] = m_old[k];
                end
            end else if (flush || disp2rn_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        model_eval();
        check("ready", int'(rn2dec_ready), int'(m_ready));
        check("alloc_cnt", int'(rn2fl_alloc_cnt), m_fire ? m_need : 0);
        check("disp_valid", int'(rn2disp_valid), int'(exp_valid));
        check("stall_cnt", int'(rn_stall_cnt), exp_stall);
        for (int k = 0; k < W; k++) begin
            check("rat_rd_addr", int'(rn2specrat_rs1[k*LW +: LW]), int'(s_lrs1[k]));
            check("wren", int'(rn2specrat_wren[k]), int'(m_wren[k]));
            if (m_wren[k]) begin
                check("waddr", int'(rn2specrat_waddr[k*LW +: LW]), int'(s_lrd[k]));
                check("wdata", int'(rn2specrat_wdata[k*PW +: PW]), m_new[k]);
            end
            check("disp_slot_valid", int'(rn2disp_slot_valid[k]), int'(e_sv[k]));
            check("disp_prd_v", int'(rn2disp_prd_v[k]), int'(e_prdv[k]));
            check("disp_prs1", int'(rn2disp_prs1[k*PW +: PW]), e_prs1[k]);
            check("disp_prs2", int'(rn2disp_prs2[k*PW +: PW]), e_prs2[k]);
            check("disp_prd", int'(rn2disp_prd[k*PW +: PW]), e_prd[k]);
            check("disp_old_prd", int'(rn2disp_old_prd[k*PW +: PW]), e_old[k]);
        end
    end

    function automatic int o_prs1(input int k); return int'(rn2disp_prs1[k*PW +: PW]); endfunction
    function automatic int o_prs2(input int k); return int'(rn2disp_prs2[k*PW +: PW]); endfunction
    function automatic int o_prd(input int k);  return int'(rn2disp_prd[k*PW +: PW]);  endfunction
    function automatic int o_old(input int k);  return int'(rn2disp_old_prd[k*PW +: PW]); endfunction
    function automatic int o_wdata(input int k); return int'(rn2specrat_wdata[k*PW +: PW]); endfunction
    function automatic int o_waddr(input int k); return int'(rn2specrat_waddr[k*LW +: LW]); endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int k, input bit sv, input int rs1, input bit v1, input int rs2,
                            input bit v2, input int rd, input bit vd, input int p1, input int p2,
                            input int pd);
        dec2rn_slot_valid[k] = sv;
        s_lrs1[k] = LW'(rs1); dec2rn_lrs1_v[k] = v1;
        s_lrs2[k] = LW'(rs2); dec2rn_lrs2_v[k] = v2;
        s_lrd[k]  = LW'(rd);  dec2rn_lrd_v[k]  = vd;
        r_prs1[k] = PW'(p1); r_prs2[k] = PW'(p2); r_prd[k] = PW'(pd);
    endtask

    task automatic set_fl(input int a, input int b, input int avail);
        fl[0] = PW'(a); fl[1] = PW'(b); fl2rn_avail = 2'(avail);
    endtask

    task automatic group_t1();
        set_slot(0, 1, 2, 1, 3, 1, 1, 1, 42, 43, 41);
        set_slot(1, 1, 1, 1, 3, 1, 4, 1, 41, 43, 44);
        set_fl(51, 52, 2);
        dec2rn_valid = 1'b1;
    endtask

    task automatic group_t2();
        set_slot(0, 1, 2, 1, 3, 1, 1, 1, 42, 43, 41);
        set_slot(1, 1, 6, 1, 7, 1, 1, 1, 46, 47, 41);
        set_fl(51, 52, 2);
        dec2rn_valid = 1'b1;
    endtask

    task automatic group_t3();
        set_slot(0, 1, 2, 1, 0, 1, 0, 1, 42, 33, 30);
        set_slot(1, 1, 0, 0, 7, 1, 5, 1, 31, 47, 45);
        set_fl(60, 61, 2);
        dec2rn_valid = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; dec2rn_valid = 1'b0; disp2rn_ready = 1'b0;
        dec2rn_slot_valid = '0; dec2rn_lrs1_v = '0; dec2rn_lrs2_v = '0; dec2rn_lrd_v = '0;
        for (int k = 0; k < W; k++) begin
            s_lrs1[k] = '0; s_lrs2[k] = '0; s_lrd[k] = '0;
            r_prs1[k] = '0; r_prs2[k] = '0; r_prd[k] = '0; fl[k] = '0;
        end
        fl2rn_avail = 2'd0;
        repeat (3) step();
        check("rst_valid", int'(rn2disp_valid), 0);
        check("rst_stall", int'(rn_stall_cnt), 0);
        reset_n = 1'b1; disp2rn_ready = 1'b1;
        step();

        // 1: RAW bypass across the pair
        group_t1(); #1;
        check("t1_alloc", int'(rn2fl_alloc_cnt), 2);
        check("t1_wren", int'(rn2specrat_wren), 3);
        check("t1_waddr0", o_waddr(0), 1);
        check("t1_wdata0", o_wdata(0), 51);
        check("t1_waddr1", o_waddr(1), 4);
        check("t1_wdata1", o_wdata(1), 52);
        step(); dec2rn_valid = 1'b0; #1;
        check("t1_valid", int'(rn2disp_valid), 1);
        check("t1_prs1_0", o_prs1(0), 42); check("t1_prs2_0", o_prs2(0), 43);
        check("t1_prd_0", o_prd(0), 51);   check("t1_old_0", o_old(0), 41);
        check("t1_prs1_1", o_prs1(1), 51); check("t1_prs2_1", o_prs2(1), 43);
        check("t1_prd_1", o_prd(1), 52);   check("t1_old_1", o_old(1), 44);

        // 2: WAW, only the younger writer updates the RAT
        group_t2(); #1;
        check("t2_wren", int'(rn2specrat_wren), 2);
        check("t2_wdata1", o_wdata(1), 52);
        check("t2_alloc", int'(rn2fl_alloc_cnt), 2);
        step(); dec2rn_valid = 1'b0; #1;
        check("t2_old_1", o_old(1), 51);
        check("t2_prd_0", o_prd(0), 51);
        check("t2_prd_1", o_prd(1), 52);
        check("t2_slot_valid", int'(rn2disp_slot_valid), 3);

        // 3: x0 destination and x0 sources
        group_t3(); #1;
        check("t3_alloc", int'(rn2fl_alloc_cnt), 1);
        check("t3_wren", int'(rn2specrat_wren), 2);
        check("t3_wdata1", o_wdata(1), 60);
        step(); dec2rn_valid = 1'b0; #1;
        check("t3_prd_v", int'(rn2disp_prd_v), 2);
        check("t3_prd_0", o_prd(0), 0);
        check("t3_prd_1", o_prd(1), 60);
        check("t3_prs2_0", o_prs2(0), 0);
        check("t3_prs1_1", o_prs1(1), 0);
        step();

        // 4: dispatch backpressure holds the group and counts stalls
        group_t1(); step();
        disp2rn_ready = 1'b0; group_t3(); #1;
        check("t4_ready", int'(rn2dec_ready), 0);
        check("t4_alloc", int'(rn2fl_alloc_cnt), 0);
        check("t4_wren", int'(rn2specrat_wren), 0);
        repeat (3) step();
        check("t4_stall", int'(rn_stall_cnt), 3);
        check("t4_hold_prd0", o_prd(0), 51);
        check("t4_hold_prs1_1", o_prs1(1), 51);
        disp2rn_ready = 1'b1; #1;
        check("t4_ready_rel", int'(rn2dec_ready), 1);
        check("t4_alloc_rel", int'(rn2fl_alloc_cnt), 1);
        step(); dec2rn_valid = 1'b0; #1;
        check("t4_prd_1", o_prd(1), 60);

        // 5: freelist shortage stalls the whole group
        group_t1(); set_fl(51, 52, 1); #1;
        check("t5_ready_short", int'(rn2dec_ready), 0);
        check("t5_alloc_short", int'(rn2fl_alloc_cnt), 0);
        step();
        check("t5_stall", int'(rn_stall_cnt), 4);
        set_fl(51, 52, 2); #1;
        check("t5_ready", int'(rn2dec_ready), 1);
        check("t5_alloc", int'(rn2fl_alloc_cnt), 2);
        step(); dec2rn_valid = 1'b0; disp2rn_ready = 1'b0; #1;
        check("t5_valid", int'(rn2disp_valid), 1);
        check("t5_prd_1", o_prd(1), 52);

        // 6: flush wins over a valid group and clears the held output
        group_t2(); flush = 1'b1; disp2rn_ready = 1'b1; #1;
        check("t6_ready", int'(rn2dec_ready), 0);
        check("t6_alloc", int'(rn2fl_alloc_cnt), 0);
        check("t6_wren", int'(rn2specrat_wren), 0);
        step(); flush = 1'b0; dec2rn_valid = 1'b0; #1;
        check("t6_valid", int'(rn2disp_valid), 0);
        check("t6_stall", int'(rn_stall_cnt), 5);

        // 7: reset discards a held group
        group_t1(); step();
        disp2rn_ready = 1'b0; dec2rn_valid = 1'b0; step();
        check("t7_held", int'(rn2disp_valid), 1);
        reset_n = 1'b0; step();
        check("t7_valid", int'(rn2disp_valid), 0);
        check("t7_prd_0", o_prd(0), 0);
        check("t7_old_1", o_old(1), 0);
        check("t7_stall", int'(rn_stall_cnt), 0);
        reset_n = 1'b1; disp2rn_ready = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
